// File: rtl/pipe_control_unit.sv
// Pipelined control unit: decodes the ID-stage opcode and carries controls through ID/EX, EX/MEM, MEM/WB.
// Optional load-use hazard detection is enabled by defining CU_HAZARD_DETECT_EN.
module pipe_control_unit #(
    parameter int OPCODE_W = 11,
    parameter int REG_W    = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [OPCODE_W-1:0] opcode_i,
    input  logic                valid_i,
    input  logic [REG_W-1:0]    rn_i,
    input  logic [REG_W-1:0]    rm_i,
    input  logic [REG_W-1:0]    rd_i,
    input  logic                flush_i,
    output logic                stall_o,
    output logic                illegal_o,
    output logic                ex_alusrc_o,
    output logic [1:0]          ex_aluop_o,
    output logic                ex_uncond_o,
    output logic                mem_read_o,
    output logic                mem_write_o,
    output logic                mem_branch_o,
    output logic [REG_W-1:0]    mem_rd_o,
    output logic                mem_regwrite_o,
    output logic                wb_regwrite_o,
    output logic                wb_memtoreg_o,
    output logic [REG_W-1:0]    wb_rd_o
);

    localparam logic [REG_W-1:0] XZR = '1;

    typedef struct packed {
        logic             aluSrc;
        logic [1:0]       aluOp;
        logic             uncond;
        logic             memRead;
        logic             memWrite;
        logic             branch;
        logic             regWrite;
        logic             memToReg;
        logic [REG_W-1:0] rd;
    } ctrl_t;

    localparam ctrl_t BUBBLE = '0;

    // Unrecognised opcodes come back as a bubble with legal cleared.
    function automatic ctrl_t decode(input logic [10:0] op, input logic [REG_W-1:0] rd,
                                     output logic legal);
        ctrl_t c;
        c     = BUBBLE;
        legal = 1'b1;
        casez (op)
            11'b11111000010: begin
                c.aluSrc   = 1'b1;
                c.memToReg = 1'b1;
                c.regWrite = 1'b1;
                c.memRead  = 1'b1;
            end
            11'b11111000000: begin
                c.aluSrc   = 1'b1;
                c.memWrite = 1'b1;
            end
            11'b10110100???: begin
                c.branch = 1'b1;
                c.aluOp  = 2'b01;
            end
            11'b000101?????: begin
                c.branch = 1'b1;
                c.uncond = 1'b1;
            end
            11'b10001011000, 11'b11001011000, 11'b10001010000, 11'b10101010000: begin
                c.regWrite = 1'b1;
                c.aluOp    = 2'b10;
            end
            default: legal = 1'b0;
        endcase
        if (legal) begin
            c.rd = rd;
            if (rd == XZR) c.regWrite = 1'b0;
        end
        return c;
    endfunction

    ctrl_t       idEx_p0, exMem_p1, memWb_p2;
    ctrl_t       decoded;
    logic        decLegal;
    logic        stallInt;
    logic        idExLoad;
    logic        illegalQ;
    logic [10:0] opField;

    assign opField = opcode_i[OPCODE_W-1 -: 11];

    always_comb begin
        decLegal = 1'b0;
        decoded  = decode(opField, rd_i, decLegal);
    end

`ifdef CU_HAZARD_DETECT_EN
    logic loadUse;
    assign loadUse  = idEx_p0.memRead && (idEx_p0.rd != XZR) && valid_i &&
                      ((idEx_p0.rd == rn_i) || (idEx_p0.rd == rm_i));
    // A flush squashes the stalled instruction anyway, so it overrides the stall.
    assign stallInt = loadUse && !flush_i;
`else
    logic unusedSrcs;
    assign unusedSrcs = ^{rn_i, rm_i};
    assign stallInt   = 1'b0;
`endif

    assign idExLoad = valid_i && !stallInt && !flush_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idEx_p0  <= BUBBLE;
            exMem_p1 <= BUBBLE;
            memWb_p2 <= BUBBLE;
            illegalQ <= 1'b0;
        end else begin
            // ID -> EX
            idEx_p0  <= idExLoad ? decoded : BUBBLE;
            // EX -> MEM
            exMem_p1 <= flush_i ? BUBBLE : idEx_p0;
            // MEM -> WB
            memWb_p2 <= exMem_p1;
            illegalQ <= valid_i && !decLegal && !stallInt;
        end
    end

    assign stall_o        = stallInt;
    assign illegal_o      = illegalQ;
    assign ex_alusrc_o    = idEx_p0.aluSrc;
    assign ex_aluop_o     = idEx_p0.aluOp;
    assign ex_uncond_o    = idEx_p0.uncond;
    assign mem_read_o     = exMem_p1.memRead;
    assign mem_write_o    = exMem_p1.memWrite;
    assign mem_branch_o   = exMem_p1.branch;
    assign mem_rd_o       = exMem_p1.rd;
    assign mem_regwrite_o = exMem_p1.regWrite;
    assign wb_regwrite_o  = memWb_p2.regWrite;
    assign wb_memtoreg_o  = memWb_p2.memToReg;
    assign wb_rd_o        = memWb_p2.rd;

endmodule

// File: tb/tb_pipe_control_unit.sv
// Directed, table-driven bench for pipe_control_unit; stage contents are listed per cycle as instruction kinds.
module tb_pipe_control_unit;

    localparam int OPCODE_W = 11;
    localparam int REG_W    = 5;

    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [10:0] OP_CBZ  = 11'b10110100101;
    localparam logic [10:0] OP_B    = 11'b00010110011;
    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_ILL  = 11'b00000000000;

    logic                clk;
    logic                rst_n;
    logic [OPCODE_W-1:0] opcode_i;
    logic                valid_i;
    logic [REG_W-1:0]    rn_i, rm_i, rd_i;
    logic                flush_i;
    logic                stall_o, illegal_o;
    logic                ex_alusrc_o, ex_uncond_o;
    logic [1:0]          ex_aluop_o;
    logic                mem_read_o, mem_write_o, mem_branch_o, mem_regwrite_o;
    logic [REG_W-1:0]    mem_rd_o;
    logic                wb_regwrite_o, wb_memtoreg_o;
    logic [REG_W-1:0]    wb_rd_o;
    logic [21:0]         allOut;

    pipe_control_unit #(.OPCODE_W(OPCODE_W), .REG_W(REG_W)) dut (
        .clk(clk), .rst_n(rst_n), .opcode_i(opcode_i), .valid_i(valid_i),
        .rn_i(rn_i), .rm_i(rm_i), .rd_i(rd_i), .flush_i(flush_i),
        .stall_o(stall_o), .illegal_o(illegal_o),
        .ex_alusrc_o(ex_alusrc_o), .ex_aluop_o(ex_aluop_o), .ex_uncond_o(ex_uncond_o),
        .mem_read_o(mem_read_o), .mem_write_o(mem_write_o), .mem_branch_o(mem_branch_o),
        .mem_rd_o(mem_rd_o), .mem_regwrite_o(mem_regwrite_o),
        .wb_regwrite_o(wb_regwrite_o), .wb_memtoreg_o(wb_memtoreg_o), .wb_rd_o(wb_rd_o)
    );

    assign allOut = {stall_o, illegal_o, ex_alusrc_o, ex_aluop_o, ex_uncond_o,
                     mem_read_o, mem_write_o, mem_branch_o, mem_regwrite_o, mem_rd_o,
                     wb_regwrite_o, wb_memtoreg_o, wb_rd_o};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef enum logic [2:0] {K_BUB, K_LDUR, K_STUR, K_CBZ, K_B, K_ALU} kind_t;

    typedef struct {
        logic [10:0] op;
        logic        vld;
        logic [4:0]  rn, rm, rd;
        logic        fl;
        logic        stall;
        logic        ill;
        kind_t       exK;
        kind_t       memK;
        logic [4:0]  memRd;
        kind_t       wbK;
        logic [4:0]  wbRd;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic addV(input logic [10:0] op, input logic vld, input logic [4:0] rn,
                        input logic [4:0] rm, input logic [4:0] rd, input logic fl,
                        input logic st, input logic il, input kind_t exK,
                        input kind_t memK, input logic [4:0] memRd,
                        input kind_t wbK, input logic [4:0] wbRd);
        vec_t v;
        v.op = op; v.vld = vld; v.rn = rn; v.rm = rm; v.rd = rd; v.fl = fl;
        v.stall = st; v.ill = il; v.exK = exK; v.memK = memK; v.memRd = memRd;
        v.wbK = wbK; v.wbRd = wbRd;
        vecs.push_back(v);
    endtask

    task automatic idle(input kind_t exK, input kind_t memK, input logic [4:0] memRd,
                        input kind_t wbK, input logic [4:0] wbRd);
        addV(OP_ILL, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, exK, memK, memRd, wbK, wbRd);
    endtask

    task automatic drive(input logic [10:0] op, input logic v, input logic [4:0] rn,
                         input logic [4:0] rm, input logic [4:0] rd, input logic fl);
        opcode_i = op; valid_i = v; rn_i = rn; rm_i = rm; rd_i = rd; flush_i = fl;
    endtask

    // {alusrc, aluop, uncond}
    function automatic logic [3:0] expEx(input kind_t k);
        case (k)
            K_LDUR, K_STUR: return 4'b1000;
            K_CBZ:          return 4'b0010;
            K_B:            return 4'b0001;
            K_ALU:          return 4'b0100;
            default:        return 4'b0000;
        endcase
    endfunction

    // {read, write, branch, regwrite, rd}
    function automatic logic [8:0] expMem(input kind_t k, input logic [4:0] rd);
        logic rw;
        rw = ((k == K_LDUR) || (k == K_ALU)) && (rd != 5'd31);
        return {k == K_LDUR, k == K_STUR, (k == K_CBZ) || (k == K_B), rw,
                (k == K_BUB) ? 5'd0 : rd};
    endfunction

    // {regwrite, memtoreg, rd}
    function automatic logic [6:0] expWb(input kind_t k, input logic [4:0] rd);
        logic rw;
        rw = ((k == K_LDUR) || (k == K_ALU)) && (rd != 5'd31);
        return {rw, k == K_LDUR, (k == K_BUB) ? 5'd0 : rd};
    endfunction

    initial begin
        // Mixed instruction stream, illegal opcode, valid_i=0 gap, ALU to XZR.
        addV(OP_ADD, 1, 1, 2, 5, 0,   0, 0, K_BUB,  K_BUB, 0,  K_BUB, 0);
        addV(OP_SUB, 1, 1, 2, 6, 0,   0, 0, K_ALU,  K_BUB, 0,  K_BUB, 0);
        addV(OP_LDUR, 1, 1, 2, 7, 0,  0, 0, K_ALU,  K_ALU, 5,  K_BUB, 0);
        addV(OP_STUR, 1, 8, 9, 10, 0, 0, 0, K_LDUR, K_ALU, 6,  K_ALU, 5);
        addV(OP_B, 1, 0, 0, 11, 0,    0, 0, K_STUR, K_LDUR, 7, K_ALU, 6);
        addV(OP_CBZ, 1, 12, 0, 13, 0, 0, 0, K_B,    K_STUR, 10, K_LDUR, 7);
        addV(OP_ILL, 1, 0, 0, 9, 0,   0, 0, K_CBZ,  K_B, 11,   K_STUR, 10);
        addV(OP_AND, 1, 1, 2, 31, 0,  0, 1, K_BUB,  K_CBZ, 13, K_B, 11);
        addV(OP_ORR, 0, 1, 2, 14, 0,  0, 0, K_ALU,  K_BUB, 0,  K_CBZ, 13);
        addV(OP_ORR, 1, 1, 2, 14, 0,  0, 0, K_BUB,  K_ALU, 31, K_BUB, 0);
        idle(K_ALU, K_BUB, 0, K_ALU, 31);
        idle(K_BUB, K_ALU, 14, K_BUB, 0);
        idle(K_BUB, K_BUB, 0, K_ALU, 14);
        idle(K_BUB, K_BUB, 0, K_BUB, 0);
        // CBZ, ADD, ADD with flush while CBZ is in MEM; then B squashed by flush.
        addV(OP_CBZ, 1, 1, 2, 1, 0,   0, 0, K_BUB, K_BUB, 0, K_BUB, 0);
        addV(OP_ADD, 1, 1, 2, 2, 0,   0, 0, K_CBZ, K_BUB, 0, K_BUB, 0);
        addV(OP_ADD, 1, 1, 2, 3, 1,   0, 0, K_ALU, K_CBZ, 1, K_BUB, 0);
        idle(K_BUB, K_BUB, 0, K_CBZ, 1);
        idle(K_BUB, K_BUB, 0, K_BUB, 0);
        addV(OP_B, 1, 0, 0, 4, 1,     0, 0, K_BUB, K_BUB, 0, K_BUB, 0);
        idle(K_BUB, K_BUB, 0, K_BUB, 0);
        // Load-use: LDUR rd=3 then ADD rn=3.
`ifdef CU_HAZARD_DETECT_EN
        addV(OP_LDUR, 1, 1, 2, 3, 0,  0, 0, K_BUB,  K_BUB, 0,  K_BUB, 0);
        addV(OP_ADD, 1, 3, 4, 5, 0,   1, 0, K_LDUR, K_BUB, 0,  K_BUB, 0);
        addV(OP_ADD, 1, 3, 4, 5, 0,   0, 0, K_BUB,  K_LDUR, 3, K_BUB, 0);
        idle(K_ALU, K_BUB, 0, K_LDUR, 3);
        idle(K_BUB, K_ALU, 5, K_BUB, 0);
        idle(K_BUB, K_BUB, 0, K_ALU, 5);
        idle(K_BUB, K_BUB, 0, K_BUB, 0);
`else
        addV(OP_LDUR, 1, 1, 2, 3, 0,  0, 0, K_BUB,  K_BUB, 0,  K_BUB, 0);
        addV(OP_ADD, 1, 3, 4, 5, 0,   0, 0, K_LDUR, K_BUB, 0,  K_BUB, 0);
        idle(K_ALU, K_LDUR, 3, K_BUB, 0);
        idle(K_BUB, K_ALU, 5, K_LDUR, 3);
        idle(K_BUB, K_BUB, 0, K_ALU, 5);
        idle(K_BUB, K_BUB, 0, K_BUB, 0);
        idle(K_BUB, K_BUB, 0, K_BUB, 0);
`endif
        // LDUR to XZR followed by a reader of XZR: no stall.
        addV(OP_LDUR, 1, 1, 2, 31, 0, 0, 0, K_BUB,  K_BUB, 0,  K_BUB, 0);
        addV(OP_ADD, 1, 31, 31, 6, 0, 0, 0, K_LDUR, K_BUB, 0,  K_BUB, 0);
        idle(K_ALU, K_LDUR, 31, K_BUB, 0);
        idle(K_BUB, K_ALU, 6, K_LDUR, 31);
        idle(K_BUB, K_BUB, 0, K_ALU, 6);
        idle(K_BUB, K_BUB, 0, K_BUB, 0);
        // Flush coinciding with a load-use hazard.
        addV(OP_LDUR, 1, 1, 2, 3, 0,  0, 0, K_BUB,  K_BUB, 0, K_BUB, 0);
        addV(OP_ADD, 1, 3, 3, 5, 1,   0, 0, K_LDUR, K_BUB, 0, K_BUB, 0);
        idle(K_BUB, K_BUB, 0, K_BUB, 0);
        idle(K_BUB, K_BUB, 0, K_BUB, 0);

        // Reset held with a valid ADD applied, then released.
        rst_n = 1'b0;
        drive(OP_ADD, 1'b1, 5'd1, 5'd2, 5'd5, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1 chk("reset_hold_outputs", 32'(allOut), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1 chk("release_ex_aluop", 32'(ex_aluop_o), 32'd2);
        chk("release_wb_regwrite_early", 32'(wb_regwrite_o), 32'd0);
        repeat (2) @(posedge clk);
        #1 chk("release_wb_regwrite", 32'(wb_regwrite_o), 32'd1);
        drive(OP_ILL, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        repeat (4) @(posedge clk);

        foreach (vecs[i]) begin
            vec_t v;
            v = vecs[i];
            @(negedge clk);
            drive(v.op, v.vld, v.rn, v.rm, v.rd, v.fl);
            #1;
            chk($sformatf("row%0d stall", i), 32'(stall_o), 32'(v.stall));
            chk($sformatf("row%0d illegal", i), 32'(illegal_o), 32'(v.ill));
            chk($sformatf("row%0d ex", i), 32'({ex_alusrc_o, ex_aluop_o, ex_uncond_o}),
                32'(expEx(v.exK)));
            chk($sformatf("row%0d mem", i),
                32'({mem_read_o, mem_write_o, mem_branch_o, mem_regwrite_o, mem_rd_o}),
                32'(expMem(v.memK, v.memRd)));
            chk($sformatf("row%0d wb", i), 32'({wb_regwrite_o, wb_memtoreg_o, wb_rd_o}),
                32'(expWb(v.wbK, v.wbRd)));
        end

        // Asynchronous reset asserted mid-pipeline discards in-flight work.
        @(negedge clk);
        drive(OP_LDUR, 1'b1, 5'd1, 5'd2, 5'd3, 1'b0);
        @(negedge clk);
        drive(OP_ADD, 1'b1, 5'd4, 5'd4, 5'd5, 1'b0);
        #1 chk("pre_reset_ex_alusrc", 32'(ex_alusrc_o), 32'd1);
        #1 rst_n = 1'b0;
        #1 chk("async_reset_outputs", 32'(allOut), 32'd0);
        @(negedge clk);
        drive(OP_ILL, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        rst_n = 1'b1;
        @(posedge clk);
        #1 chk("post_reset_discard", 32'(allOut), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_control_unit.md
PIPE_CONTROL_UNIT -- requirements
Module: pipe_control_unit

Interface
REQ-001 SHALL have parameter OPCODE_W, default 11, opcode field width (>= 11); decode uses bits [OPCODE_W-1 -: 11].
REQ-002 SHALL have parameter REG_W, default 5, register-index width; index all-ones = XZR.
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 opcode_i  in  OPCODE_W  ID-stage instruction opcode.
REQ-007 valid_i  in  1  ID-stage instruction valid.
REQ-008 rn_i, rm_i, rd_i  in  REG_W each  ID-stage source and destination indices.
REQ-009 flush_i  in  1  branch taken in MEM; squash younger stages.
REQ-010 stall_o  out  1  hold PC and IF/ID this cycle.
REQ-011 illegal_o  out  1  one-cycle pulse, unrecognised valid opcode decoded.
REQ-012 ex_alusrc_o, ex_aluop_o[1:0], ex_uncond_o  out  EX-stage controls.
REQ-013 mem_read_o, mem_write_o, mem_branch_o, mem_rd_o[REG_W], mem_regwrite_o  out  MEM-stage controls and forwarding info.
REQ-014 wb_regwrite_o, wb_memtoreg_o, wb_rd_o[REG_W]  out  WB-stage controls.

Function
REQ-015 Decode SHALL be combinational: LDUR 11111000010 -> alusrc,memtoreg,regwrite,memread,aluop 00; STUR 11111000000 -> alusrc,memwrite,aluop 00; CBZ 10110100xxx -> branch,aluop 01; B 000101xxxxx -> branch,uncond; ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000 -> regwrite,aluop 10.
REQ-016 Any other opcode with valid_i=1 SHALL decode to all-zero controls (bubble) and pulse illegal_o on the next cycle.
REQ-017 SHALL hold three control registers ID/EX, EX/MEM, MEM/WB; each stage's outputs come directly from its register (EX latency 1, MEM 2, WB 3 cycles after decode).
REQ-018 ID/EX SHALL load decoded controls plus rd_i when valid_i=1, stall_o=0, flush_i=0; otherwise it loads a bubble (all controls 0, rd = 0).
REQ-019 EX/MEM SHALL load a bubble when flush_i=1; otherwise it SHALL take ID/EX.
REQ-020 MEM/WB SHALL always take EX/MEM; flush_i SHALL NOT affect it.
REQ-021 regwrite SHALL be forced to 0 in ID/EX when rd_i is XZR.
REQ-022 stall_o (load-use) SHALL be 1 when ID/EX memread=1, ID/EX rd != XZR, valid_i=1, and ID/EX rd equals rn_i or rm_i; combinational, same cycle.
REQ-023 Stall SHALL last exactly one cycle per hazard, because the bubble clears ID/EX memread.
REQ-024 flush_i and stall_o together: flush SHALL win; both ID/EX and EX/MEM take bubbles and stall_o SHALL be forced to 0.
REQ-025 B (uncond=1) SHALL still be squashed by a concurrent flush_i.

Reset
REQ-026 rst_n=0 SHALL asynchronously clear all three stage registers and illegal_o; every output SHALL read 0 while reset is asserted.
REQ-027 Reset deasserted mid-pipeline SHALL discard in-flight instructions; the first decode after release enters ID/EX on the first rising edge with rst_n=1.

Configuration
REQ-028 Macro CU_HAZARD_DETECT_EN defined: load-use detection per REQ-022..REQ-024.
REQ-029 Macro CU_HAZARD_DETECT_EN undefined: stall_o tied to 0, and ID/EX loads on valid_i alone; all other behaviour unchanged.

Verification
REQ-030 Reset: hold rst_n=0 with valid ADD applied -> all outputs 0; release -> ex_aluop_o=10 after 1 edge, wb_regwrite_o=1 after 3 edges.
REQ-031 LDUR rd=3, then ADD rn=3 -> stall_o=1 for one cycle, one bubble in EX, ADD reaches EX one cycle later; with macro undefined, stall_o=0 and there is no bubble.
REQ-032 CBZ then two ADDs; flush_i=1 when CBZ is in MEM -> both ADDs reach WB with wb_regwrite_o=0; CBZ's MEM/WB state is unaffected.
REQ-033 opcode 11'b00000000000, valid_i=1 -> illegal_o pulses 1 for exactly one cycle; all stage controls 0 for that slot.
REQ-034 ADD rd=31 -> wb_regwrite_o=0; LDUR rd=31 followed by ADD rn=31 -> no stall.
REQ-035 flush_i=1 coinciding with a load-use hazard -> stall_o=0, ID/EX and EX/MEM bubbles next cycle.
